// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_PARITY = 4;

    function automatic logic [7:0] status_byte(input logic par, input logic ovf,
                                               input logic busy, input logic full,
                                               input logic empty);
        logic [7:0] v;
        v            = 8'h00;
        v[ST_EMPTY]  = empty;
        v[ST_FULL]   = full;
        v[ST_BUSY]   = busy;
        v[ST_OVF]    = ovf;
        v[ST_PARITY] = par;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with combinational head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_FULL);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO and polled status.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       tx,
    output logic       irq
);
    import uart_pkg::*;

    // state   | meaning
    // IDLE    | line high, pops the FIFO head as soon as one is present
    // START   | start bit (low)
    // DATA    | eight data bits, LSB first
    // PARITY  | even parity bit (parity build only)
    // STOP    | stop bit (high)

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic HAS_PARITY = 1'b1;
`else
    localparam logic HAS_PARITY = 1'b0;
`endif

    logic             w_wr;
    logic             w_rd;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_baud_done;
    logic [7:0]       w_head;
    logic [FIFO_AW:0] w_count;

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_irq;
    logic              r_ovf;
    logic [7:0]        r_data_out;
`ifdef UART_TX_PARITY_EN
    logic              r_par;
`endif

    assign w_wr        = cs && !rw;
    assign w_rd        = cs && rw;
    assign w_push      = w_wr && (addr == REG_DATA);
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_busy      = (r_state != IDLE);
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign data_out = r_data_out;
    assign tx       = r_tx;
    assign irq      = r_irq;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (data_in),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // A dropped push only counts as overflow when no pop frees a slot that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf      <= 1'b0;
            r_irq      <= 1'b1;
            r_data_out <= 8'h00;
        end else begin
            if (w_wr && (addr == REG_CTRL))
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            r_irq <= (w_count == '0) && !w_busy;
            if (w_rd)
                r_data_out <= (addr == REG_STATUS) ?
                              status_byte(HAS_PARITY, r_ovf, w_busy, w_full, w_empty) : 8'h00;
        end
    end

    // r_tx is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed bus steps with random payloads,
// decoded off the serial line and compared with a byte-level expectation.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b0;
    logic       rw = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       tx;
    logic       irq;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] bq[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line receiver: samples every bit at its middle and records byte + start cycle.
    initial begin
        int         s;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                s = cyc;
                d = 8'h00;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) rx_bad++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    d[k] = tx;
                end
                if (PAR) begin
                    repeat (CPB) @(negedge clk);
                    if (tx !== ^d) rx_bad++;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) rx_bad++;
                rx_q.push_back(d);
                rx_t.push_back(s);
                @(negedge clk);
            end
        end
    end

    function automatic logic [7:0] stat(input bit ovf, input bit busy, input bit full, input bit empty);
        return {3'b000, PAR, ovf, busy, full, empty};
    endfunction

    // Line level expected 'off' cycles after the start bit began.
    function automatic logic frame_bit(input logic [7:0] d, input int off);
        int slot;
        if (off < 0) return 1'b1;
        slot = off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (PAR && slot == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0;
        v = data_out;
    endtask

    task automatic burst(input int n, output int w1);
        w1 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) w1 = cyc + 1;
            cs = 1'b1; rw = 1'b0; addr = 2'd0; data_in = bq[i];
        end
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic gen_bytes(input int n);
        logic [7:0] b;
        bq.delete();
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hEE);
            bq.push_back(b);
        end
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (cyc < target && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    task automatic wait_rx(input int n);
        int g = 0;
        while (rx_q.size() < n && g < n * (FRAME + 1) + 200) begin
            @(negedge clk);
            g++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic compare_rx(input int first_start);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        if (rx_t.size() > 0) check("first_start", 32'(rx_t[0]), 32'(first_start));
        for (int i = 1; i < rx_t.size(); i++)
            check("frame_gap", 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME + 1));
    endtask

    task automatic frame_test(input logic [7:0] d);
        int s;
        int off;
        rx_q.delete(); rx_t.delete();
        write_reg(2'd0, d);
        s = cyc + 1;
        do begin
            @(negedge clk);
            off = cyc - s;
            check("tx_level", 32'(tx), 32'(frame_bit(d, off)));
            if (off == 10) begin
                cs = 1'b1; rw = 1'b1; addr = 2'd1;
            end
            if (off == 11) begin
                cs = 1'b0;
                check("status_in_frame", 32'(data_out), 32'(stat(0, 1, 0, 1)));
            end
            if (off == FRAME)     check("irq_at_idle", 32'(irq), 32'd0);
            if (off == FRAME + 1) check("irq_rise", 32'(irq), 32'd1);
        end while (off < FRAME + 1);
        check("frame_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("frame_rx_byte", 32'(rx_q[0]), 32'(d));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] extra;
        int         w1;
        int         s;
        int         highs;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd1);
        reset = 1'b1;

        // Register reads
        read_reg(2'd1, v); check("status_idle", 32'(v), 32'(stat(0, 0, 0, 1)));
        read_reg(2'd3, v); check("read_reserved", 32'(v), 32'd0);
        read_reg(2'd1, v); check("status_idle2", 32'(v), 32'(stat(0, 0, 0, 1)));
        read_reg(2'd0, v); check("read_data_reg", 32'(v), 32'd0);
        read_reg(2'd1, v);
        read_reg(2'd2, v); check("read_ctrl_reg", 32'(v), 32'd0);

        // Single frames
        frame_test(8'hA5);
        read_reg(2'd1, v); check("status_after_frame", 32'(v), 32'(stat(0, 0, 0, 1)));
        frame_test(8'($urandom_range(0, 255)));
`ifdef UART_TX_PARITY_EN
        frame_test(8'h07);
`endif

        // Burst of 16 back-to-back writes
        repeat (5) @(negedge clk);
        rx_q.delete(); rx_t.delete();
        gen_bytes(16);
        exp_q = bq;
        burst(16, w1);
        read_reg(2'd1, v); check("status_burst", 32'(v), 32'(stat(0, 1, 0, 0)));
        wait_rx(16);
        compare_rx(w1 + 1);
        repeat (10) @(negedge clk);

        // Overflow: fill while busy, then one more byte
        rx_q.delete(); rx_t.delete();
        gen_bytes(17);
        exp_q = bq;
        bq.push_back(8'hEE);
        burst(18, w1);
        read_reg(2'd1, v); check("status_ovf", 32'(v), 32'(stat(1, 1, 1, 0)));
        write_reg(2'd2, 8'($urandom_range(0, 255)));
        read_reg(2'd1, v); check("status_ovf_clear", 32'(v), 32'(stat(0, 1, 1, 0)));
        wait_rx(17);
        repeat (2 * FRAME) @(negedge clk);
        check("no_dropped_byte", 32'(rx_q.size()), 32'd17);
        compare_rx(w1 + 1);
        repeat (10) @(negedge clk);

        // Push into a full FIFO on the cycle IDLE pops
        rx_q.delete(); rx_t.delete();
        gen_bytes(17);
        extra = 8'($urandom_range(0, 255));
        exp_q = bq;
        exp_q.push_back(extra);
        burst(17, w1);
        s = w1 + 1;
        read_reg(2'd1, v); check("status_full", 32'(v), 32'(stat(0, 1, 1, 0)));
        wait_until(s + FRAME);
        cs = 1'b1; rw = 1'b0; addr = 2'd0; data_in = extra;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
        read_reg(2'd1, v); check("status_push_pop_full", 32'(v), 32'(stat(0, 1, 1, 0)));
        wait_rx(18);
        compare_rx(s);
        check("framing_errors", 32'(rx_bad), 32'd0);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3
        gen_bytes(3);
        burst(3, w1);
        s = w1 + 1;
        read_reg(2'd1, v); check("status_pre_reset", 32'(v), 32'(stat(0, 1, 0, 0)));
        wait_until(s + 4 * CPB + 1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_data_out", 32'(data_out), 32'd0);
        check("midreset_irq", 32'(irq), 32'd1);
        reset = 1'b1;
        read_reg(2'd1, v); check("status_post_reset", 32'(v), 32'(stat(0, 0, 0, 1)));
        highs = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b1) highs++;
        end
        check("quiet_after_reset", 32'(highs), 32'd100);
        check("irq_after_reset", 32'(irq), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU bus. It is a peer of the RAM and LED display register and is selected by the top-level address decoder.
- The CPU writes bytes into a transmit FIFO. The block serialises them as 8N1 on `tx`, LSB first.
- The CPU polls a status register to read FIFO and line state.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 16, transmit FIFO entries. Must be a power of two, ≥2.
- FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- cs  in  1  chip select from the address decoder.
- rw  in  1  1 = read, 0 = write (CPU convention).
- addr  in  2  register index.
- data_in  in  8  CPU write data.
- data_out  out  8  registered read data.
- tx  out  1  serial line; idles high.
- irq  out  1  level interrupt: FIFO empty and transmitter idle.

Behaviour:
- Register map:
  - 0 DATA: write pushes data_in into the FIFO. Read returns 0x00.
  - 1 STATUS: read returns {4'b0, ovf, busy, full, empty}.
  - 2 CTRL: write of any value clears ovf. Read returns 0x00.
  - 3 reserved: writes ignored, reads return 0x00.
- Bus access:
  - Write occurs when cs=1 and rw=0, in a single cycle.
  - Read: when cs=1 and rw=1, data_out updates on the next clk edge (1-cycle latency, same as RAM).
  - When no read is selected, data_out holds its last value.
- Reset values (while reset=0 at a clk edge): tx=1, data_out=0x00, irq=1, FIFO empty, ovf=0, FSM=IDLE, baud counter=0, bit index=0.
- FIFO:
  - Circular buffer with rd/wr pointers of FIFO_AW bits and a count of FIFO_AW+1 bits.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Push while full: the byte is dropped, ovf is set (sticky), and the FIFO is unchanged.
  - Push while full with a pop in the same cycle: push is accepted, count is unchanged, ovf is not set.
  - Push and pop in the same cycle when not full: both take effect, count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If not empty, pop the head into the shift register, clear the baud counter, go to START. The pop happens in that same cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - Back-to-back bytes: IDLE can pop on the cycle it is entered, so inter-frame gap = 1 cycle.
  - Baud counter counts 0..CLKS_PER_BIT-1. The state or bit advances on terminal count.
- Frame length: 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle.
- Derived outputs:
  - busy = (state != IDLE).
  - irq = empty && !busy, registered (1-cycle delay from the condition).
- Reset asserted mid-frame: tx returns to 1 on the next edge, FIFO contents are discarded, and no partial byte is resumed.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - Adds state PARITY between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
  - STATUS bit 4 reads 1 (parity present).
- Not defined: no PARITY state, 8N1 framing, STATUS bit 4 reads 0.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, STOP, PARITY}.
  - register index localparams REG_DATA=0, REG_STATUS=1, REG_CTRL=2.
  - STATUS bit-position localparams.
- One natural sub-module, sync_fifo:
  - Parameters WIDTH=8, DEPTH.
  - Ports clk, reset, push, din, pop, dout, full, empty, count.
  - Implements the push-when-full-with-pop rule above.
  - Overflow detection stays in uart_tx_mmio.

Test Plan:
- Single byte: CLKS_PER_BIT=4; write 0xA5 to addr 0.
  - tx = 0 (start), then bits 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles.
  - Stop bit ends 40 cycles after the start bit begins.
  - STATUS during the frame = 0x05 (busy, empty); after the frame = 0x01.
  - irq rises one cycle after return to IDLE.
- Burst: write 0x01..0x10 (16 bytes) back-to-back.
  - STATUS shows full=1 after the 16th write if the transmitter has not yet popped; otherwise count=15.
  - All 16 bytes appear on tx in order with a 1-cycle gap between frames.
- Overflow: hold the transmitter busy, fill the FIFO, write 0xEE.
  - ovf=1 and 0xEE is never transmitted.
  - Write to addr 2: STATUS bit 3 returns to 0.
- Simultaneous push and pop while full: time a write to the IDLE pop cycle.
  - Byte accepted, count stays 16, ovf remains 0.
- Reset mid-frame: assert reset=0 during DATA bit 3.
  - Next edge: tx=1, STATUS=0x01, data_out=0x00.
  - After release, no further frames are sent.
- Read latency: read addr 1 in cycle N; data_out is valid at cycle N+1. Read addr 3 returns 0x00.
- Parity (UART_TX_PARITY_EN): send 0x07.
  - Parity bit = 1; frame length = 44 cycles at CLKS_PER_BIT=4.
